pc_next_unit: RTL
=================

Name: pc_next_unit

Overview:
- Parametrised program-counter block for the MIPS monocycle datapath, successor to the branch/jump target adder.
- Holds the PC register and computes PC+4, the branch target (PC+4 + sext(imm)<<2), the J-type target and the JR target.
- Selects the next PC by control priority, supports stall, traps misaligned targets to an error vector, and counts taken redirects.
- Sits between the control unit/ALU zero flag and the instruction memory address input.

Parameters:
- WIDTH, 32, address width in bits; legal range is WIDTH >= 28.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset, truncated to WIDTH.
- ERROR_VECTOR, 32'h0000_0080, PC loaded on a misaligned target, truncated to WIDTH.
- CNT_WIDTH, 16, width of the redirect counter.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = PC advances; 0 = stall, all state holds.
- branch_eq  input  1  BEQ decoded.
- branch_ne  input  1  BNE decoded.
- zero  input  1  ALU zero flag.
- jump  input  1  J/JAL decoded.
- jump_reg  input  1  JR decoded.
- imediato  input  16  branch offset in words, signed.
- indice  input  26  J-type index field.
- endereco_reg  input  WIDTH  rs register value for JR.
- limpa_erro  input  1  clears the sticky error flag.
- endereco_PC  output  WIDTH  current PC (register output).
- endereco_PC4  output  WIDTH  PC+4, also used as the JAL link value.
- desvio_tomado  output  1  combinational; a redirect is selected this cycle.
- erro_alinhamento  output  1  sticky misaligned-target flag.
- contador_desvios  output  CNT_WIDTH  count of accepted redirects.

Behaviour:
- Reset (reset_n=0, asynchronous, immediate):
  - endereco_PC = RESET_VECTOR[WIDTH-1:0]
  - erro_alinhamento = 0
  - contador_desvios = 0
  - Reset asserted mid-operation overrides everything; the first edge after release executes from RESET_VECTOR.
- Arithmetic: all sums are modulo 2^WIDTH; no carry out, wrap-around is silent.
  - pc4 = endereco_PC + 4
  - alvo_branch = pc4 + ({sign-extended imediato to WIDTH} << 2)
  - alvo_jump = {pc4[WIDTH-1:28], indice, 2'b00}; when WIDTH == 28 it is {indice, 2'b00}.
  - alvo_jr = endereco_reg
- Branch condition: taken = (branch_eq & zero) | (branch_ne & ~zero).
- Next-PC priority, highest first: jump_reg > jump > taken branch > pc4.
  - Simultaneous controls resolve by this priority only.
- desvio_tomado = jump_reg | jump | taken. It is combinational and independent of enable.
- Alignment check: misaligned if the selected next PC has bits [1:0] != 0.
  - Only JR can produce this, because the other targets are word-aligned by construction.
- On a rising edge with enable=1:
  - If misaligned: endereco_PC <= ERROR_VECTOR and erro_alinhamento <= 1.
  - Otherwise: endereco_PC <= selected next PC.
  - If desvio_tomado: contador_desvios increments, saturating at 2^CNT_WIDTH-1. A misaligned JR still counts.
- On a rising edge with enable=0:
  - endereco_PC, contador_desvios and erro_alinhamento hold.
  - No error is set while stalled.
  - limpa_erro is still honoured.
- limpa_erro:
  - Clears erro_alinhamento on the edge.
  - If a new misalignment is set on the same edge, set wins and the flag stays 1.
- Latency:
  - Next PC appears on endereco_PC one edge after the controls are presented.
  - endereco_PC4 and desvio_tomado follow endereco_PC and the inputs combinationally, with zero latency.
- No internal FSM beyond the registers: PC, sticky flag and saturating counter.

Test Plan:
1. Reset and sequential fetch: hold reset_n=0, release, enable=1, no controls for 3 edges -> endereco_PC goes 0x0, 0x4, 0x8, 0xC; contador_desvios = 0; erro_alinhamento = 0.
2. Branches at PC=0x100:
   - branch_eq=1, zero=1, imediato=0xFFFE -> next PC 0xFC, desvio_tomado=1, counter +1.
   - Repeat with zero=1 but branch_ne=1 instead -> next PC 0x104, counter unchanged.
3. Jump and priority at PC=0x0040_0000:
   - jump=1, indice=0x0000010 -> next PC 0x0000_0040.
   - Same cycle also with jump_reg=1, endereco_reg=0x200 -> next PC 0x200.
4. Misaligned JR:
   - jump_reg=1, endereco_reg=0x202 -> next PC 0x80, erro_alinhamento=1.
   - limpa_erro=1 with a misaligned JR on the same edge -> flag stays 1.
   - limpa_erro alone -> flag 0.
5. Stall and wrap:
   - At PC=0xFFFF_FFFC with enable=0 for 2 edges -> PC holds.
   - enable=1 -> PC wraps to 0x0.
   - With CNT_WIDTH=2, 5 taken jumps -> counter saturates at 3.
6. Asynchronous reset mid-run: assert reset_n=0 between edges while PC=0x20 -> PC becomes RESET_VECTOR immediately, and counter and flag become 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter unit for the MIPS monocycle datapath: holds the PC and selects the next PC.
// Sources are sequential, branch, J-type and JR targets; misaligned targets are trapped to an error vector.
module pc_next_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] ERROR_VECTOR = 32'h0000_0080,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 branch_eq,
  input  logic                 branch_ne,
  input  logic                 zero,
  input  logic                 jump,
  input  logic                 jump_reg,
  input  logic [15:0]          imediato,
  input  logic [25:0]          indice,
  input  logic [WIDTH-1:0]     endereco_reg,
  input  logic                 limpa_erro,
  output logic [WIDTH-1:0]     endereco_PC,
  output logic [WIDTH-1:0]     endereco_PC4,
  output logic                 desvio_tomado,
  output logic                 erro_alinhamento,
  output logic [CNT_WIDTH-1:0] contador_desvios
);

  localparam logic [WIDTH-1:0]     RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0]     ERR_PC  = WIDTH'(ERROR_VECTOR);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] pc4;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] alvo_branch;
  logic [WIDTH-1:0] alvo_jump;
  logic [WIDTH-1:0] next_pc;
  logic             taken;
  logic             misaligned;

  // All sums wrap modulo 2^WIDTH; the carry out is intentionally dropped.
  assign pc4         = endereco_PC + WIDTH'(4);
  assign offset      = {{(WIDTH-18){imediato[15]}}, imediato, 2'b00};
  assign alvo_branch = pc4 + offset;

  generate
    if (WIDTH == 28) begin : g_jump_narrow
      assign alvo_jump = {indice, 2'b00};
    end else begin : g_jump_wide
      assign alvo_jump = {pc4[WIDTH-1:28], indice, 2'b00};
    end
  endgenerate

  assign taken         = (branch_eq & zero) | (branch_ne & ~zero);
  assign desvio_tomado = jump_reg | jump | taken;
  assign endereco_PC4  = pc4;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_pc = pc4;
    if (jump_reg) begin
      next_pc = endereco_reg;
    end else if (jump) begin
      next_pc = alvo_jump;
    end else if (taken) begin
      next_pc = alvo_branch;
    end
  end

  // Only a JR target can be misaligned; the other targets end in 2'b00 by construction.
  assign misaligned = |next_pc[1:0];

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      endereco_PC <= RST_PC;
    end else if (enable) begin
      endereco_PC <= misaligned ? ERR_PC : next_pc;
    end
  end

  // A new misalignment wins over a simultaneous clear; the clear still works while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      erro_alinhamento <= 1'b0;
    end else if (enable && misaligned) begin
      erro_alinhamento <= 1'b1;
    end else if (limpa_erro) begin
      erro_alinhamento <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      contador_desvios <= '0;
    end else if (enable && desvio_tomado && (contador_desvios != CNT_MAX)) begin
      contador_desvios <= contador_desvios + CNT_WIDTH'(1);
    end
  end

endmodule
